// File: rtl/modexp_io_port.sv
// Operand loader and result streamer for the ModExp core. It assembles five
// OP_W-bit operands from word streams and replays the core result word by word.
module modexp_io_port #(
    parameter int DATA_WIDTH = 64,
    parameter int WORDS      = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        startInput,
    input  logic                        in_valid,
    input  logic [DATA_WIDTH-1:0]       m_buf,
    input  logic [DATA_WIDTH-1:0]       e_buf,
    input  logic [DATA_WIDTH-1:0]       n_buf,
    input  logic [DATA_WIDTH-1:0]       r_buf,
    input  logic [DATA_WIDTH-1:0]       t_buf,
    output logic [DATA_WIDTH*WORDS-1:0] m_op,
    output logic [DATA_WIDTH*WORDS-1:0] e_op,
    output logic [DATA_WIDTH*WORDS-1:0] n_op,
    output logic [DATA_WIDTH*WORDS-1:0] r_op,
    output logic [DATA_WIDTH*WORDS-1:0] t_op,
    output logic                        operands_ready,
    input  logic                        result_valid,
    input  logic [DATA_WIDTH*WORDS-1:0] result_in,
    input  logic                        getResult,
    input  logic                        res_ready,
    output logic [DATA_WIDTH-1:0]       res_out,
    output logic                        res_valid,
    output logic                        res_last,
    output logic [2:0]                  port_state
);

    localparam int OP_W = DATA_WIDTH * WORDS;
    localparam int CW   = $clog2(WORDS) + 1;
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_READY  = 3'd2,
        S_HELD   = 3'd3,
        S_OUTPUT = 3'd4
    } state_t;

    state_t            state, state_next;
    logic [CW-1:0]     k, j, idx;
    logic [OP_W-1:0]   hold;
    logic              restart, load_word, capture_last, final_accept;

    // A restart from LOAD/READY captures a simultaneous word as word 0.
    always_comb begin
        restart      = startInput && (state == S_IDLE || state == S_LOAD || state == S_READY);
        idx          = startInput ? '0 : k;
        load_word    = in_valid && (state == S_LOAD || (startInput && state == S_READY));
        capture_last = load_word && (idx == LAST);
        final_accept = (state == S_OUTPUT) && res_ready && (j == LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (startInput) state_next = S_LOAD;
            S_LOAD:   if (capture_last) state_next = S_READY;
            S_READY: begin
                if (startInput)        state_next = capture_last ? S_READY : S_LOAD;
                else if (result_valid) state_next = S_HELD;
            end
            S_HELD:   if (getResult) state_next = S_OUTPUT;
            S_OUTPUT: if (final_accept) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        res_valid  = (state == S_OUTPUT);
        res_last   = (state == S_OUTPUT) && (j == LAST);
        res_out    = '0;
        port_state = state;
        if (state == S_OUTPUT) res_out = hold[j*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            k              <= '0;
            j              <= '0;
            operands_ready <= 1'b0;
            hold           <= '0;
            m_op           <= '0;
            e_op           <= '0;
            n_op           <= '0;
            r_op           <= '0;
            t_op           <= '0;
        end else begin
            if (restart) begin
                k              <= '0;
                operands_ready <= 1'b0;
            end
            if (load_word) begin
                m_op[idx*DATA_WIDTH +: DATA_WIDTH] <= m_buf;
                e_op[idx*DATA_WIDTH +: DATA_WIDTH] <= e_buf;
                n_op[idx*DATA_WIDTH +: DATA_WIDTH] <= n_buf;
                r_op[idx*DATA_WIDTH +: DATA_WIDTH] <= r_buf;
                t_op[idx*DATA_WIDTH +: DATA_WIDTH] <= t_buf;
                k <= idx + 1'b1;
            end
            if (capture_last) operands_ready <= 1'b1;
            if (final_accept) operands_ready <= 1'b0;
            if (state == S_READY && result_valid && !startInput) hold <= result_in;
            if (state == S_HELD && getResult) begin
                j <= '0;
            end else if (state == S_OUTPUT && res_ready) begin
                j <= (j == LAST) ? '0 : j + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_modexp_io_port.sv
// Randomised bench for modexp_io_port; expected operands and result words are
// rebuilt from the streamed word lists, independent of the DUT's internals.
module tb_modexp_io_port;

    localparam int DW  = 64;
    localparam int NW  = 64;
    localparam int OPW = DW * NW;

    logic           clk = 1'b0;
    logic           reset, startInput, in_valid, result_valid, getResult, res_ready;
    logic [DW-1:0]  m_buf, e_buf, n_buf, r_buf, t_buf;
    logic [OPW-1:0] m_op, e_op, n_op, r_op, t_op, result_in;
    logic           operands_ready, res_valid, res_last;
    logic [DW-1:0]  res_out;
    logic [2:0]     port_state;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0]  wd[5][NW];
    logic [OPW-1:0] exp_op[5];
    logic [OPW-1:0] exp_res;

    modexp_io_port #(.DATA_WIDTH(DW), .WORDS(NW)) dut (
        .clk(clk), .reset(reset), .startInput(startInput), .in_valid(in_valid),
        .m_buf(m_buf), .e_buf(e_buf), .n_buf(n_buf), .r_buf(r_buf), .t_buf(t_buf),
        .m_op(m_op), .e_op(e_op), .n_op(n_op), .r_op(r_op), .t_op(t_op),
        .operands_ready(operands_ready), .result_valid(result_valid),
        .result_in(result_in), .getResult(getResult), .res_ready(res_ready),
        .res_out(res_out), .res_valid(res_valid), .res_last(res_last),
        .port_state(port_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_word(int i);
        m_buf = wd[0][i];
        e_buf = wd[1][i];
        n_buf = wd[2][i];
        r_buf = wd[3][i];
        t_buf = wd[4][i];
    endtask

    task automatic build_expected();
        for (int o = 0; o < 5; o++)
            for (int i = 0; i < NW; i++)
                exp_op[o][i*DW +: DW] = wd[o][i];
    endtask

    task automatic set_spec_words();
        for (int o = 0; o < 5; o++)
            for (int i = 0; i < NW; i++)
                wd[o][i] = '0;
        wd[0][0] = 64'd8;
        wd[1][0] = 64'd13;
        wd[2][0] = 64'd77;
    endtask

    task automatic set_random_words();
        for (int o = 0; o < 5; o++)
            for (int i = 0; i < NW; i++)
                wd[o][i] = {$urandom, $urandom};
    endtask

    function automatic logic [OPW-1:0] dut_op(int o);
        case (o)
            0:       return m_op;
            1:       return e_op;
            2:       return n_op;
            3:       return r_op;
            default: return t_op;
        endcase
    endfunction

    function automatic int first_diff(logic [OPW-1:0] a, logic [OPW-1:0] b);
        for (int i = 0; i < NW; i++)
            if (a[i*DW +: DW] !== b[i*DW +: DW]) return i;
        return -1;
    endfunction

    task automatic idle_inputs();
        startInput = 0; in_valid = 0; result_valid = 0; getResult = 0; res_ready = 0;
        result_in = '0; m_buf = '0; e_buf = '0; n_buf = '0; r_buf = '0; t_buf = '0;
    endtask

    task automatic test_reset();
        logic [OPW-1:0] a;
        int d;
        idle_inputs();
        reset = 1; startInput = 1; in_valid = 1; getResult = 1; result_valid = 1; res_ready = 1;
        m_buf = {$urandom, $urandom}; e_buf = m_buf; n_buf = m_buf; r_buf = m_buf; t_buf = m_buf;
        result_in = {NW{64'hFFFF_0000_1234_5678}};
        tick(); tick();
        total++; if (port_state !== 3'd0) begin bad++; $display("FAIL reset_state got %0d want 0", port_state); end
        total++; if (operands_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got %b want 0", operands_ready); end
        total++; if ({res_valid, res_last} !== 2'b00) begin bad++; $display("FAIL reset_flags got %b want 00", {res_valid, res_last}); end
        total++; if (res_out !== '0) begin bad++; $display("FAIL reset_res_out got %h want 0", res_out); end
        for (int o = 0; o < 5; o++) begin
            a = dut_op(o);
            d = first_diff(a, '0);
            total++;
            if (d >= 0) begin bad++; $display("FAIL reset_op%0d word %0d got %h want 0", o, d, a[d*DW +: DW]); end
        end
        idle_inputs();
        reset = 0;
        result_valid = 1; getResult = 1; result_in = {NW{64'h1}};
        tick();
        result_valid = 0; getResult = 0;
        tick();
        total++; if (port_state !== 3'd0 || res_valid !== 1'b0) begin bad++; $display("FAIL idle_ignore state=%0d res_valid=%b want 0/0", port_state, res_valid); end
    endtask

    task automatic test_load_contiguous();
        logic [OPW-1:0] a;
        int d;
        set_spec_words();
        build_expected();
        startInput = 1; in_valid = 1; put_word(NW-1);
        tick();
        startInput = 0;
        total++; if (port_state !== 3'd1) begin bad++; $display("FAIL start_to_load got %0d want 1", port_state); end
        for (int i = 0; i < NW; i++) begin
            in_valid = 1; put_word(i);
            tick();
            if (i < NW-1) begin
                total++;
                if (operands_ready !== 1'b0) begin bad++; $display("FAIL contig_early_ready word %0d got %b want 0", i, operands_ready); end
            end
        end
        in_valid = 0;
        total++; if (operands_ready !== 1'b1) begin bad++; $display("FAIL contig_ready got %b want 1", operands_ready); end
        total++; if (port_state !== 3'd2) begin bad++; $display("FAIL contig_state got %0d want 2", port_state); end
        for (int o = 0; o < 5; o++) begin
            a = dut_op(o);
            d = first_diff(a, exp_op[o]);
            total++;
            if (d >= 0) begin bad++; $display("FAIL contig_op%0d word %0d got %h want %h", o, d, a[d*DW +: DW], exp_op[o][d*DW +: DW]); end
        end
    endtask

    task automatic test_result_stream();
        int idx;
        getResult = 1;
        tick();
        getResult = 0;
        total++; if (port_state !== 3'd2) begin bad++; $display("FAIL early_get got %0d want 2", port_state); end
        exp_res = OPW'(64);
        result_valid = 1; result_in = exp_res;
        tick();
        result_valid = 0; result_in = '0;
        total++; if (port_state !== 3'd3 || operands_ready !== 1'b1) begin bad++; $display("FAIL to_held state=%0d ready=%b want 3/1", port_state, operands_ready); end
        getResult = 1;
        tick();
        getResult = 0;
        total++; if (port_state !== 3'd4) begin bad++; $display("FAIL to_output got %0d want 4", port_state); end
        res_ready = 1;
        idx = 0;
        while (idx < NW) begin
            total++;
            if (res_valid !== 1'b1 || res_out !== exp_res[idx*DW +: DW] || res_last !== (idx == NW-1)) begin
                bad++;
                $display("FAIL stream word %0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                         idx, res_valid, res_out, res_last, exp_res[idx*DW +: DW], idx == NW-1);
            end
            tick();
            idx++;
        end
        res_ready = 0;
        total++; if (port_state !== 3'd0 || res_valid !== 1'b0 || operands_ready !== 1'b0) begin
            bad++; $display("FAIL stream_end state=%0d v=%b ready=%b want 0/0/0", port_state, res_valid, operands_ready);
        end
    endtask

    task automatic test_load_gapped();
        logic [OPW-1:0] a;
        int d;
        set_spec_words();
        build_expected();
        startInput = 1;
        tick();
        startInput = 0;
        for (int c = 0; c < 2*NW; c++) begin
            in_valid = c[0]; put_word(c / 2);
            tick();
            if (c < 2*NW-1) begin
                total++;
                if (operands_ready !== 1'b0) begin bad++; $display("FAIL gap_early_ready cycle %0d got %b want 0", c, operands_ready); end
            end
        end
        in_valid = 0;
        total++; if (operands_ready !== 1'b1 || port_state !== 3'd2) begin bad++; $display("FAIL gap_ready ready=%b state=%0d want 1/2", operands_ready, port_state); end
        for (int o = 0; o < 5; o++) begin
            a = dut_op(o);
            d = first_diff(a, exp_op[o]);
            total++;
            if (d >= 0) begin bad++; $display("FAIL gap_op%0d word %0d got %h want %h", o, d, a[d*DW +: DW], exp_op[o][d*DW +: DW]); end
        end
    endtask

    task automatic test_stall();
        logic [OPW-1:0] a;
        logic [DW-1:0]  held;
        int d, k, idx, c;
        bit pat[4];
        bit acc, stalled;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        set_random_words();
        build_expected();
        startInput = 1;
        tick();
        startInput = 0;
        k = 0; c = 0;
        while (k < NW && c < 2000) begin
            in_valid = 1'($urandom_range(0, 1)); put_word(k);
            tick();
            if (in_valid) k++;
            c++;
        end
        in_valid = 0;
        total++; if (operands_ready !== 1'b1) begin bad++; $display("FAIL rnd_ready got %b want 1", operands_ready); end
        for (int o = 0; o < 5; o++) begin
            a = dut_op(o);
            d = first_diff(a, exp_op[o]);
            total++;
            if (d >= 0) begin bad++; $display("FAIL rnd_op%0d word %0d got %h want %h", o, d, a[d*DW +: DW], exp_op[o][d*DW +: DW]); end
        end
        for (int i = 0; i < NW; i++) exp_res[i*DW +: DW] = {$urandom, $urandom};
        result_valid = 1; result_in = exp_res;
        tick();
        result_valid = 0; result_in = ~exp_res;
        startInput = 1;
        tick();
        startInput = 0;
        total++; if (port_state !== 3'd3) begin bad++; $display("FAIL held_ignore_start got %0d want 3", port_state); end
        result_valid = 1;
        tick();
        result_valid = 0;
        getResult = 1;
        tick();
        getResult = 0;
        startInput = 1;
        tick();
        startInput = 0;
        total++; if (port_state !== 3'd4) begin bad++; $display("FAIL output_ignore_start got %0d want 4", port_state); end
        idx = 0; c = 0; stalled = 0; held = '0;
        while (idx < NW && c < 1000) begin
            res_ready = pat[c % 4];
            total++;
            if (res_valid !== 1'b1 || res_out !== exp_res[idx*DW +: DW] || res_last !== (idx == NW-1)) begin
                bad++;
                $display("FAIL stall word %0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                         idx, res_valid, res_out, res_last, exp_res[idx*DW +: DW], idx == NW-1);
            end
            if (stalled) begin
                total++;
                if (res_out !== held) begin bad++; $display("FAIL stall_stable word %0d got %h want %h", idx, res_out, held); end
            end
            held = res_out;
            acc = res_ready;
            stalled = !acc;
            tick();
            if (acc) idx++;
            c++;
        end
        res_ready = 0;
        total++; if (idx != NW || port_state !== 3'd0) begin bad++; $display("FAIL stall_end accepted=%0d state=%0d want %0d/0", idx, port_state, NW); end
    endtask

    task automatic test_restart();
        logic [OPW-1:0] a;
        int d;
        set_random_words();
        startInput = 1;
        tick();
        startInput = 0;
        for (int i = 0; i < 30; i++) begin
            in_valid = 1; put_word(i);
            tick();
        end
        set_random_words();
        build_expected();
        startInput = 1; in_valid = 1; put_word(0);
        tick();
        startInput = 0;
        total++; if (port_state !== 3'd1 || operands_ready !== 1'b0) begin bad++; $display("FAIL restart state=%0d ready=%b want 1/0", port_state, operands_ready); end
        for (int i = 1; i < NW; i++) begin
            in_valid = 1; put_word(i);
            tick();
        end
        in_valid = 0;
        total++; if (operands_ready !== 1'b1 || port_state !== 3'd2) begin bad++; $display("FAIL restart_done ready=%b state=%0d want 1/2", operands_ready, port_state); end
        for (int o = 0; o < 5; o++) begin
            a = dut_op(o);
            d = first_diff(a, exp_op[o]);
            total++;
            if (d >= 0) begin bad++; $display("FAIL restart_op%0d word %0d got %h want %h", o, d, a[d*DW +: DW], exp_op[o][d*DW +: DW]); end
        end
        startInput = 1;
        tick();
        startInput = 0;
        total++; if (port_state !== 3'd1 || operands_ready !== 1'b0) begin bad++; $display("FAIL ready_restart state=%0d ready=%b want 1/0", port_state, operands_ready); end
    endtask

    task automatic test_reset_mid_load();
        logic [OPW-1:0] a;
        int d;
        set_random_words();
        startInput = 1;
        tick();
        startInput = 0;
        for (int i = 0; i < 40; i++) begin
            in_valid = 1; put_word(i);
            tick();
        end
        reset = 1; put_word(40);
        tick();
        reset = 0; in_valid = 0;
        total++; if (port_state !== 3'd0 || operands_ready !== 1'b0 || res_valid !== 1'b0 || res_out !== '0) begin
            bad++; $display("FAIL midload_reset state=%0d ready=%b v=%b d=%h want 0/0/0/0", port_state, operands_ready, res_valid, res_out);
        end
        for (int o = 0; o < 5; o++) begin
            a = dut_op(o);
            d = first_diff(a, '0);
            total++;
            if (d >= 0) begin bad++; $display("FAIL midload_op%0d word %0d got %h want 0", o, d, a[d*DW +: DW]); end
        end
        getResult = 1;
        tick();
        getResult = 0;
        for (int c = 0; c < 3; c++) begin
            total++;
            if (port_state !== 3'd0 || res_valid !== 1'b0) begin bad++; $display("FAIL midload_get state=%0d v=%b want 0/0", port_state, res_valid); end
            tick();
        end
    endtask

    task automatic test_reset_mid_output();
        set_random_words();
        startInput = 1;
        tick();
        startInput = 0;
        for (int i = 0; i < NW; i++) begin
            in_valid = 1; put_word(i);
            tick();
        end
        in_valid = 0;
        result_valid = 1; result_in = {NW{64'hA5A5_5A5A_0F0F_F0F0}};
        tick();
        result_valid = 0;
        getResult = 1;
        tick();
        getResult = 0;
        res_ready = 1;
        for (int i = 0; i < 10; i++) tick();
        total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL midout_active got v=%b want 1", res_valid); end
        reset = 1;
        tick();
        reset = 0;
        for (int c = 0; c < 5; c++) begin
            total++;
            if (res_valid !== 1'b0 || res_out !== '0 || port_state !== 3'd0) begin
                bad++; $display("FAIL midout_reset cycle %0d v=%b d=%h state=%0d want 0/0/0", c, res_valid, res_out, port_state);
            end
            tick();
        end
        res_ready = 0;
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_load_contiguous();
        test_result_stream();
        test_load_gapped();
        test_stall();
        test_restart();
        test_reset_mid_load();
        test_reset_mid_output();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
